// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared sizes, types and the one-hot check for the datapath
//                register file and its upstream 5-to-32 decoder.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_WIDTH  = 64;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ZERO_REG   = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_WIDTH-1:0]  reg_word_t;

    // True when exactly one bit of the select vector is set.
    function automatic logic is_onehot(input logic [NUM_REGS-1:0] sel);
        int unsigned count;
        count = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count += {31'd0, sel[i]};
        end
        return (count == 1);
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port
//  Description : One registered read port: 32:1 mux over the storage array,
//                hardwired-zero override and write-to-read bypass.
//  Ports       : clock, reset_n      - clock / async active-low reset
//                regs                - storage array contents
//                rd_addr             - register number to read
//                wr_strobe           - qualified write to a real register
//                wr_idx, wr_data     - index and data of that write
//                rd_data             - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      regs [NUM_REGS],
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  wr_strobe,
    input  logic [REG_ADDR_W-1:0] wr_idx,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data
);

    localparam logic [REG_ADDR_W-1:0] C_ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    logic [WIDTH-1:0] w_next;

    // wr_strobe is never raised for the zero register, so the zero override
    // only has to cover plain reads of it.
    always_comb begin
        w_next = regs[rd_addr];
        if (rd_addr == C_ZERO_ADDR) begin
            w_next = '0;
        end else if (wr_strobe && (wr_idx == rd_addr)) begin
            w_next = wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= w_next;
        end
    end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : 32 x 64-bit register file, one one-hot-selected write port,
//                two registered read ports with bypass, register 31 fixed 0.
//  Ports       : clock, reset_n        - clock / async active-low reset
//                wr_en, wr_sel, wr_data - write request, one-hot select, data
//                rd_addr_a, rd_addr_b  - read register numbers
//                rd_data_a, rd_data_b  - registered read data
//                wr_err                - sticky malformed-select flag
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [NUM_REGS-1:0]   wr_sel,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]      rd_data_a,
    output logic [WIDTH-1:0]      rd_data_b,
    output logic                  wr_err
);

    logic [WIDTH-1:0]      r_regs [NUM_REGS];
    logic                  w_sel_onehot;
    logic                  w_wr_legal;
    logic                  w_wr_strobe;
    logic [REG_ADDR_W-1:0] w_wr_idx;

    assign w_sel_onehot = is_onehot(wr_sel);
    assign w_wr_legal   = wr_en && w_sel_onehot;
    // A legal write to the zero register is accepted but changes nothing,
    // so it must not reach the storage or the bypass.
    assign w_wr_strobe  = w_wr_legal && !wr_sel[ZERO_REG];

    // Encode the one-hot select; only meaningful when the select is one-hot.
    always_comb begin
        w_wr_idx = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel[i]) begin
                w_wr_idx = w_wr_idx | REG_ADDR_W'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            if (gi == ZERO_REG) begin : g_zero
                assign r_regs[gi] = '0;
            end else begin : g_store
                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        r_regs[gi] <= '0;
                    end else if (w_wr_legal && wr_sel[gi]) begin
                        r_regs[gi] <= wr_data;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_err <= 1'b0;
        end else if (wr_en && !w_sel_onehot) begin
            wr_err <= 1'b1;
        end
    end

    regfile_read_port #(.WIDTH(WIDTH)) u_port_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .regs      (r_regs),
        .rd_addr   (rd_addr_a),
        .wr_strobe (w_wr_strobe),
        .wr_idx    (w_wr_idx),
        .wr_data   (wr_data),
        .rd_data   (rd_data_a)
    );

    regfile_read_port #(.WIDTH(WIDTH)) u_port_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .regs      (r_regs),
        .rd_addr   (rd_addr_b),
        .wr_strobe (w_wr_strobe),
        .wr_idx    (w_wr_idx),
        .wr_data   (wr_data),
        .rd_data   (rd_data_b)
    );

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Directed self-checking bench for register_file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    logic        clock;
    logic        reset_n;
    logic        wr_en;
    logic [31:0] wr_sel;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic        wr_err;

    int checks = 0;
    int errors = 0;

    register_file dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_err    (wr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [63:0] data);
        wr_en   = 1'b1;
        wr_sel  = 32'd1 << idx;
        wr_data = data;
        cyc();
        wr_en   = 1'b0;
        wr_sel  = '0;
    endtask

    initial begin
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_sel    = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;

        // Reset state
        cyc(); cyc();
        chk("reset_rd_a", rd_data_a, 64'h0);
        chk("reset_rd_b", rd_data_b, 64'h0);
        chk("reset_err", {63'd0, wr_err}, 64'h0);
        reset_n = 1'b1;
        cyc();

        // Basic write / read
        wr(5, 64'hDEAD_BEEF_0000_0001);
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd6;
        cyc();
        chk("basic_rd_a5", rd_data_a, 64'hDEAD_BEEF_0000_0001);
        chk("basic_rd_b6", rd_data_b, 64'h0);

        // Bypass: old value 0x99, same-edge write of 0x1234 on both ports
        wr(7, 64'h99);
        wr_en     = 1'b1;
        wr_sel    = 32'h0000_0080;
        wr_data   = 64'h1234;
        rd_addr_a = 5'd7;
        rd_addr_b = 5'd7;
        cyc();
        wr_en  = 1'b0;
        wr_sel = '0;
        chk("bypass_a", rd_data_a, 64'h1234);
        chk("bypass_b", rd_data_b, 64'h1234);
        cyc();
        chk("bypass_stored_a", rd_data_a, 64'h1234);

        // Back-to-back writes to reg 7, each visible in its own cycle
        wr_en = 1'b1; wr_sel = 32'h0000_0080; wr_data = 64'h1;
        cyc();
        chk("b2b_first", rd_data_a, 64'h1);
        wr_data = 64'h2;
        cyc();
        chk("b2b_second", rd_data_b, 64'h2);
        wr_en = 1'b0; wr_sel = '0;
        cyc();
        chk("b2b_last_wins", rd_data_a, 64'h2);

        // Zero register: legal write ignored, no error
        wr_en     = 1'b1;
        wr_sel    = 32'h8000_0000;
        wr_data   = 64'hFFFF_FFFF_FFFF_FFFF;
        rd_addr_a = 5'd31;
        rd_addr_b = 5'd31;
        cyc();
        wr_en = 1'b0; wr_sel = '0;
        chk("zero_bypass_a", rd_data_a, 64'h0);
        chk("zero_bypass_b", rd_data_b, 64'h0);
        chk("zero_no_err", {63'd0, wr_err}, 64'h0);
        cyc();
        chk("zero_read_a", rd_data_a, 64'h0);

        // Write disabled: malformed selects ignored
        wr_en = 1'b0; wr_sel = 32'h0;
        cyc();
        chk("dis_sel0_no_err", {63'd0, wr_err}, 64'h0);
        wr_sel = 32'h0000_0003; wr_data = 64'hEEEE;
        rd_addr_a = 5'd0;
        cyc();
        chk("dis_sel3_no_err", {63'd0, wr_err}, 64'h0);
        chk("dis_sel3_no_write", rd_data_a, 64'h0);
        wr_sel = '0;

        // Malformed select with regs 0/1 preloaded
        wr(0, 64'hA);
        wr(1, 64'hB);
        wr_en     = 1'b1;
        wr_sel    = 32'h0000_0003;
        wr_data   = 64'hFFFF_0000_FFFF_0000;
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd1;
        cyc();
        wr_en = 1'b0; wr_sel = '0;
        chk("mal_same_edge_a", rd_data_a, 64'hA);
        chk("mal_same_edge_b", rd_data_b, 64'hB);
        chk("mal_err_set", {63'd0, wr_err}, 64'h1);
        cyc();
        chk("mal_kept_a", rd_data_a, 64'hA);
        chk("mal_kept_b", rd_data_b, 64'hB);
        wr_en = 1'b1; wr_sel = 32'h0; wr_data = 64'h77; rd_addr_a = 5'd0;
        cyc();
        wr_en = 1'b0;
        chk("mal_zero_sel_no_write", rd_data_a, 64'hA);
        rd_addr_a = 5'd2;
        wr(2, 64'h55);
        chk("legal_after_err_a", rd_data_a, 64'h55);
        chk("err_sticky", {63'd0, wr_err}, 64'h1);

        // Sweep: write i+100 to regs 0..30, then read all on both ports
        for (int i = 0; i < 31; i++) begin
            wr(i, 64'(i + 100));
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            cyc();
            chk($sformatf("sweep_a%0d", i), rd_data_a,
                (i == 31) ? 64'h0 : 64'(i + 100));
            chk($sformatf("sweep_b%0d", 31 - i), rd_data_b,
                (i == 0) ? 64'h0 : 64'(131 - i));
        end

        // Asynchronous reset mid-run, coinciding with a pending write
        wr_en = 1'b1; wr_sel = 32'h0000_0020; wr_data = 64'hCAFE;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_a", rd_data_a, 64'h0);
        chk("async_rst_b", rd_data_b, 64'h0);
        chk("async_rst_err", {63'd0, wr_err}, 64'h0);
        cyc();
        wr_en = 1'b0; wr_sel = '0;
        reset_n = 1'b1;
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd5;
        cyc();
        chk("post_rst_reg5_a", rd_data_a, 64'h0);
        chk("post_rst_reg5_b", rd_data_b, 64'h0);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(i);
            cyc();
            chk($sformatf("post_rst_a%0d", i), rd_data_a, 64'h0);
        end
        chk("post_rst_err", {63'd0, wr_err}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire
